// File: rtl/multicycle_control_fsm.sv
// ----------------------------------------------------------------------------
// multicycle_control_fsm
//   Multi-cycle control unit for the MIPS-subset datapath. Sequences fetch,
//   decode, execute, memory and writeback for ADD, SUB, ADDI, SUBI, BEQ, BNEQ,
//   BGEZ, J, JAL, JR, LW and SW, drives every datapath strobe each cycle and
//   counts retired instructions.
//
//   Optional feature macro: OVERFLOW_TRAP_EN
//     defined   : signed overflow in EXEC_R/EXEC_I skips writeback -> ERROR
//     undefined : overflow is ignored, writeback proceeds normally
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   opcode/funct/rt_field instruction register fields
//   alu_zero/alu_neg      ALU flags used by branch resolution
//   overflow              ALU signed overflow (EXEC states only)
//   mem_ready             memory completes the current access
//   pc_write, pc_src      PC load and source select
//   iord, mem_read,
//   mem_write             unified memory address select and strobes
//   ir_write              instruction register load
//   reg_write, reg_dst,
//   mem_to_reg            register file write control
//   alu_src_a/b, alu_op   ALU operand and operation select
//   illegal               one-cycle pulse on an undecodable instruction
//   error                 high while in the sticky ERROR state
//   retired               completed-instruction count (wraps)
// ----------------------------------------------------------------------------
module multicycle_control_fsm #(
   parameter logic [5:0]  SUBI_OPCODE = 6'h0E,
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic [4:0]       rt_field,
   input  logic             alu_zero,
   input  logic             alu_neg,
   input  logic             overflow,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             iord,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             reg_write,
   output logic [1:0]       reg_dst,
   output logic [1:0]       mem_to_reg,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [2:0]       alu_op,
   output logic             illegal,
   output logic             error,
   output logic [CNT_W-1:0] retired
);

   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNEQ   = 6'h05;
   localparam logic [5:0] OP_ADDI   = 6'h08;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_SW     = 6'h2B;
   localparam logic [5:0] FN_JR     = 6'h08;
   localparam logic [5:0] FN_ADD    = 6'h20;
   localparam logic [5:0] FN_SUB    = 6'h22;
   localparam logic [4:0] RT_BGEZ   = 5'd1;

   localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_BRANCH, S_JUMP, S_JAL, S_JR,
      S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_WB_R, S_WB_I, S_WB_MEM, S_ERROR
   } state_t;

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [CNT_W-1:0]  retired_q, retired_d;
   logic              retire;
   logic              timed_out;
   logic              trap;

`ifdef OVERFLOW_TRAP_EN
   assign trap = overflow;
`else
   // Overflow is not a control input in this build.
   logic overflow_unused;
   assign overflow_unused = overflow;
   assign trap = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_FETCH;
         wait_q    <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      retire     = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'd0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 2'd0;
      mem_to_reg = 2'd0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      alu_op     = 3'd0;
      illegal    = 1'b0;
      error      = 1'b0;
      // Reached after MEM_TIMEOUT consecutive cycles in a wait state.
      timed_out  = (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

      // Strobes are forced low while reset is asserted.
      if (!reset) begin
         case (state_q)
            S_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 2'd1;
               if (mem_ready) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
                  state_d  = S_DECODE;
               end else if (timed_out) begin
                  state_d = S_ERROR;
               end
            end
            S_DECODE: begin
               alu_src_b = 2'd3;
               if (opcode == OP_RTYPE && (funct == FN_ADD || funct == FN_SUB))
                  state_d = S_EXEC_R;
               else if (opcode == OP_RTYPE && funct == FN_JR)
                  state_d = S_JR;
               else if (opcode == OP_ADDI || opcode == SUBI_OPCODE)
                  state_d = S_EXEC_I;
               else if (opcode == OP_BEQ || opcode == OP_BNEQ ||
                        (opcode == OP_REGIMM && rt_field == RT_BGEZ))
                  state_d = S_BRANCH;
               else if (opcode == OP_J)
                  state_d = S_JUMP;
               else if (opcode == OP_JAL)
                  state_d = S_JAL;
               else if (opcode == OP_LW || opcode == OP_SW)
                  state_d = S_MEM_ADDR;
               else begin
                  // Undecodable: retire as a NOP.
                  illegal = 1'b1;
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
            end
            S_EXEC_R: begin
               alu_src_a = 1'b1;
               alu_op    = 3'd2;
               state_d   = trap ? S_ERROR : S_WB_R;
            end
            S_EXEC_I: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'd2;
               alu_op    = (opcode == SUBI_OPCODE) ? 3'd1 : 3'd0;
               state_d   = trap ? S_ERROR : S_WB_I;
            end
            S_BRANCH: begin
               alu_src_a = 1'b1;
               alu_op    = 3'd1;
               retire    = 1'b1;
               state_d   = S_FETCH;
               if ((opcode == OP_BEQ && alu_zero) ||
                   (opcode == OP_BNEQ && !alu_zero) ||
                   (opcode == OP_REGIMM && !alu_neg)) begin
                  pc_write = 1'b1;
                  pc_src   = 2'd1;
               end
            end
            S_JUMP: begin
               pc_write = 1'b1;
               pc_src   = 2'd2;
               retire   = 1'b1;
               state_d  = S_FETCH;
            end
            S_JAL: begin
               pc_write   = 1'b1;
               pc_src     = 2'd2;
               reg_write  = 1'b1;
               reg_dst    = 2'd2;
               mem_to_reg = 2'd2;
               retire     = 1'b1;
               state_d    = S_FETCH;
            end
            S_JR: begin
               pc_write = 1'b1;
               pc_src   = 2'd3;
               retire   = 1'b1;
               state_d  = S_FETCH;
            end
            S_MEM_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'd2;
               state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
               iord     = 1'b1;
               mem_read = 1'b1;
               if (mem_ready)      state_d = S_WB_MEM;
               else if (timed_out) state_d = S_ERROR;
            end
            S_MEM_WR: begin
               iord      = 1'b1;
               mem_write = 1'b1;
               if (mem_ready) begin
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end else if (timed_out) begin
                  state_d = S_ERROR;
               end
            end
            S_WB_R: begin
               reg_write = 1'b1;
               reg_dst   = 2'd1;
               retire    = 1'b1;
               state_d   = S_FETCH;
            end
            S_WB_I: begin
               reg_write = 1'b1;
               retire    = 1'b1;
               state_d   = S_FETCH;
            end
            S_WB_MEM: begin
               reg_write  = 1'b1;
               mem_to_reg = 2'd1;
               retire     = 1'b1;
               state_d    = S_FETCH;
            end
            S_ERROR: begin
               error = 1'b1;
            end
            default: begin
               state_d = S_ERROR;
            end
         endcase
      end

      // Counter restarts whenever a state is entered, so it only ever
      // measures consecutive cycles spent waiting in one state.
      wait_d    = (state_d == state_q) ? wait_q + 1'b1 : '0;
      retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
   end

   assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

   localparam int unsigned TIMEOUT = 16;
   localparam int unsigned CW      = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [5:0]    opcode = '0;
   logic [5:0]    funct = '0;
   logic [4:0]    rt_field = '0;
   logic          alu_zero = 1'b0;
   logic          alu_neg = 1'b0;
   logic          overflow = 1'b0;
   logic          mem_ready = 1'b0;
   logic          pc_write;
   logic [1:0]    pc_src;
   logic          iord;
   logic          mem_read;
   logic          mem_write;
   logic          ir_write;
   logic          reg_write;
   logic [1:0]    reg_dst;
   logic [1:0]    mem_to_reg;
   logic          alu_src_a;
   logic [1:0]    alu_src_b;
   logic [2:0]    alu_op;
   logic          illegal;
   logic          error;
   logic [CW-1:0] retired;

   multicycle_control_fsm #(
      .SUBI_OPCODE(6'h0E),
      .MEM_TIMEOUT(TIMEOUT),
      .CNT_W(CW)
   ) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
      .rt_field(rt_field), .alu_zero(alu_zero), .alu_neg(alu_neg),
      .overflow(overflow), .mem_ready(mem_ready), .pc_write(pc_write),
      .pc_src(pc_src), .iord(iord), .mem_read(mem_read),
      .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal(illegal),
      .error(error), .retired(retired)
   );

   always #5 clk = ~clk;

   logic [19:0] ctl_now;
   assign ctl_now = {pc_write, pc_src, iord, mem_read, mem_write, ir_write,
                     reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                     alu_op, illegal, error};

   typedef struct {
      logic [5:0]    op;
      logic [5:0]    fn;
      logic [4:0]    rt;
      logic          z;
      logic          n;
      logic          v;
      logic          rdy;
      logic [19:0]   ctl;
      logic [CW-1:0] ret;
      string         tag;
   } ent_t;

   ent_t          sb[$];
   ent_t          e;
   int unsigned   n_pass = 0;
   int unsigned   n_total = 0;
   logic [CW-1:0] exp_ret = '0;
   logic [5:0]    cur_op;
   logic [5:0]    cur_fn;
   logic [4:0]    cur_rt;
   logic          cur_z, cur_n, cur_v;

   function automatic logic [19:0] mk(input int pcw, input int pcs, input int io,
      input int mr, input int mw, input int irw, input int rw, input int rd,
      input int m2r, input int asa, input int asb, input int aop, input int ill,
      input int err);
      return {1'(pcw), 2'(pcs), 1'(io), 1'(mr), 1'(mw), 1'(irw), 1'(rw),
              2'(rd), 2'(m2r), 1'(asa), 2'(asb), 3'(aop), 1'(ill), 1'(err)};
   endfunction

   task automatic push(input string tag, input logic rdy, input logic [19:0] ctl,
                       input bit last);
      ent_t x;
      x.op = cur_op; x.fn = cur_fn; x.rt = cur_rt;
      x.z = cur_z; x.n = cur_n; x.v = cur_v;
      x.rdy = rdy; x.ctl = ctl; x.ret = exp_ret; x.tag = tag;
      sb.push_back(x);
      if (last) exp_ret = exp_ret + 1'b1;
   endtask

   // Reference model: expected per-cycle strobes for one instruction.
   task automatic queue_instr(input string tag, input logic [5:0] op,
      input logic [5:0] fn, input logic [4:0] rt, input logic z, input logic n,
      input logic v, input int unsigned fwait, input int unsigned mwait);
      bit ok;
      bit taken;
      bit is_lw;
      int unsigned nw;
      cur_op = op; cur_fn = fn; cur_rt = rt; cur_z = z; cur_n = n; cur_v = v;
      for (int unsigned i = 0; i < fwait; i++)
         push({tag, ":fetch_wait"}, 1'b0, mk(0,0,0,1,0,0,0,0,0,0,1,0,0,0), 1'b0);
      push({tag, ":fetch"}, 1'b1, mk(1,0,0,1,0,1,0,0,0,0,1,0,0,0), 1'b0);
      ok = (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h08)) ||
           op == 6'h08 || op == 6'h0E || op == 6'h04 || op == 6'h05 ||
           (op == 6'h01 && rt == 5'd1) || op == 6'h02 || op == 6'h03 ||
           op == 6'h23 || op == 6'h2B;
      push({tag, ":decode"}, 1'b0, mk(0,0,0,0,0,0,0,0,0,0,3,0,ok ? 0 : 1,0), !ok);
      if (!ok) return;
      if (op == 6'h00 && fn == 6'h08) begin
         push({tag, ":jr"}, 1'b0, mk(1,3,0,0,0,0,0,0,0,0,0,0,0,0), 1'b1);
      end else if (op == 6'h00 || op == 6'h08 || op == 6'h0E) begin
         if (op == 6'h00)
            push({tag, ":exec_r"}, 1'b0, mk(0,0,0,0,0,0,0,0,0,1,0,2,0,0), 1'b0);
         else
            push({tag, ":exec_i"}, 1'b0,
                 mk(0,0,0,0,0,0,0,0,0,1,2,(op == 6'h0E) ? 1 : 0,0,0), 1'b0);
`ifdef OVERFLOW_TRAP_EN
         if (v) begin
            repeat (3) push({tag, ":error"}, 1'b1, mk(0,0,0,0,0,0,0,0,0,0,0,0,0,1), 1'b0);
            return;
         end
`endif
         push({tag, ":wb"}, 1'b0,
              mk(0,0,0,0,0,0,1,(op == 6'h00) ? 1 : 0,0,0,0,0,0,0), 1'b1);
      end else if (op == 6'h04 || op == 6'h05 || op == 6'h01) begin
         taken = (op == 6'h04) ? z : (op == 6'h05) ? !z : !n;
         push({tag, ":branch"}, 1'b0,
              mk(taken ? 1 : 0, taken ? 1 : 0,0,0,0,0,0,0,0,1,0,1,0,0), 1'b1);
      end else if (op == 6'h02) begin
         push({tag, ":jump"}, 1'b0, mk(1,2,0,0,0,0,0,0,0,0,0,0,0,0), 1'b1);
      end else if (op == 6'h03) begin
         push({tag, ":jal"}, 1'b0, mk(1,2,0,0,0,0,1,2,2,0,0,0,0,0), 1'b1);
      end else begin
         is_lw = (op == 6'h23);
         push({tag, ":mem_addr"}, 1'b0, mk(0,0,0,0,0,0,0,0,0,1,2,0,0,0), 1'b0);
         nw = (mwait >= TIMEOUT) ? TIMEOUT : mwait;
         for (int unsigned i = 0; i < nw; i++)
            push({tag, ":mem_wait"}, 1'b0,
                 is_lw ? mk(0,0,1,1,0,0,0,0,0,0,0,0,0,0)
                       : mk(0,0,1,0,1,0,0,0,0,0,0,0,0,0), 1'b0);
         if (mwait >= TIMEOUT) begin
            repeat (3) push({tag, ":error"}, 1'b1, mk(0,0,0,0,0,0,0,0,0,0,0,0,0,1), 1'b0);
            return;
         end
         if (is_lw) begin
            push({tag, ":mem_rd"}, 1'b1, mk(0,0,1,1,0,0,0,0,0,0,0,0,0,0), 1'b0);
            push({tag, ":wb_mem"}, 1'b0, mk(0,0,0,0,0,0,1,0,1,0,0,0,0,0), 1'b1);
         end else begin
            push({tag, ":mem_wr"}, 1'b1, mk(0,0,1,0,1,0,0,0,0,0,0,0,0,0), 1'b1);
         end
      end
   endtask

   // Drive one cycle's inputs and move to the sampling point (negedge).
   task automatic step(input ent_t x);
      opcode = x.op; funct = x.fn; rt_field = x.rt;
      alu_zero = x.z; alu_neg = x.n; overflow = x.v; mem_ready = x.rdy;
      @(negedge clk);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      mem_ready = 1'b0;
      tick();
      reset = 1'b0;
      sb.delete();
      exp_ret = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      n_total++;
      if (ctl_now !== 20'h0) $display("FAIL reset_strobes: got %05h want 00000", ctl_now);
      else n_pass++;
      n_total++;
      if (retired !== '0) $display("FAIL reset_retired: got %0d want 0", retired);
      else n_pass++;
      tick();
      reset = 1'b0;
      sb.delete();
      exp_ret = '0;
      queue_instr("rst_j", 6'h02, 6'h00, 5'd0, 1'b0, 1'b0, 1'b0, 0, 0);
      queue_instr("rst_add", 6'h00, 6'h20, 5'd0, 1'b0, 1'b0, 1'b0, 0, 0);
      repeat (5) begin
         e = sb.pop_front();
         step(e);
         n_total++;
         if (ctl_now !== e.ctl || retired !== e.ret)
            $display("FAIL %s: got ctl=%05h ret=%0d want ctl=%05h ret=%0d",
                     e.tag, ctl_now, retired, e.ctl, e.ret);
         else n_pass++;
         tick();
      end
      // Now in EXEC_R of the ADD: check it, then reset asynchronously.
      e = sb.pop_front();
      step(e);
      n_total++;
      if (ctl_now !== e.ctl || retired !== e.ret)
         $display("FAIL %s: got ctl=%05h ret=%0d want ctl=%05h ret=%0d",
                  e.tag, ctl_now, retired, e.ctl, e.ret);
      else n_pass++;
      reset = 1'b1;
      #1;
      n_total++;
      if (ctl_now !== 20'h0 || reg_write !== 1'b0)
         $display("FAIL midreset_strobes: got %05h want 00000", ctl_now);
      else n_pass++;
      n_total++;
      if (retired !== '0) $display("FAIL midreset_retired: got %0d want 0", retired);
      else n_pass++;
      tick();
      reset = 1'b0;
      sb.delete();
      exp_ret = '0;
      queue_instr("post_rst_add", 6'h00, 6'h20, 5'd0, 1'b0, 1'b0, 1'b0, 0, 0);
      while (sb.size() != 0) begin
         e = sb.pop_front();
         step(e);
         n_total++;
         if (ctl_now !== e.ctl || retired !== e.ret)
            $display("FAIL %s: got ctl=%05h ret=%0d want ctl=%05h ret=%0d",
                     e.tag, ctl_now, retired, e.ctl, e.ret);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_alu();
      queue_instr("add", 6'h00, 6'h20, 5'd0, 1'b0, 1'b0, 1'b0, 0, 0);
      queue_instr("sub_fwait", 6'h00, 6'h22, 5'd0, 1'b1, 1'b1, 1'b0, 2, 0);
      queue_instr("addi", 6'h08, 6'h00, 5'd3, 1'b0, 1'b0, 1'b0, 0, 0);
      queue_instr("subi", 6'h0E, 6'h00, 5'd3, 1'b0, 1'b1, 1'b0, 1, 0);
      while (sb.size() != 0) begin
         e = sb.pop_front();
         step(e);
         n_total++;
         if (ctl_now !== e.ctl || retired !== e.ret)
            $display("FAIL %s: got ctl=%05h ret=%0d want ctl=%05h ret=%0d",
                     e.tag, ctl_now, retired, e.ctl, e.ret);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_branch();
      queue_instr("beq_taken", 6'h04, 6'h00, 5'd0, 1'b1, 1'b0, 1'b0, 0, 0);
      queue_instr("beq_not", 6'h04, 6'h00, 5'd0, 1'b0, 1'b0, 1'b0, 0, 0);
      queue_instr("bneq_not", 6'h05, 6'h00, 5'd0, 1'b1, 1'b0, 1'b0, 0, 0);
      queue_instr("bneq_taken", 6'h05, 6'h00, 5'd0, 1'b0, 1'b1, 1'b0, 0, 0);
      queue_instr("bgez_taken", 6'h01, 6'h00, 5'd1, 1'b0, 1'b0, 1'b0, 0, 0);
      queue_instr("bgez_not", 6'h01, 6'h00, 5'd1, 1'b1, 1'b1, 1'b0, 0, 0);
      while (sb.size() != 0) begin
         e = sb.pop_front();
         step(e);
         n_total++;
         if (ctl_now !== e.ctl || retired !== e.ret)
            $display("FAIL %s: got ctl=%05h ret=%0d want ctl=%05h ret=%0d",
                     e.tag, ctl_now, retired, e.ctl, e.ret);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_jump();
      queue_instr("j", 6'h02, 6'h00, 5'd0, 1'b0, 1'b0, 1'b0, 0, 0);
      queue_instr("jal", 6'h03, 6'h00, 5'd0, 1'b0, 1'b0, 1'b0, 0, 0);
      queue_instr("jr", 6'h00, 6'h08, 5'd0, 1'b0, 1'b0, 1'b0, 0, 0);
      while (sb.size() != 0) begin
         e = sb.pop_front();
         step(e);
         n_total++;
         if (ctl_now !== e.ctl || retired !== e.ret)
            $display("FAIL %s: got ctl=%05h ret=%0d want ctl=%05h ret=%0d",
                     e.tag, ctl_now, retired, e.ctl, e.ret);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_mem();
      queue_instr("lw", 6'h23, 6'h00, 5'd2, 1'b0, 1'b0, 1'b0, 0, 0);
      queue_instr("lw_wait3", 6'h23, 6'h00, 5'd2, 1'b0, 1'b0, 1'b0, 0, 3);
      queue_instr("sw", 6'h2B, 6'h00, 5'd2, 1'b0, 1'b0, 1'b0, 0, 0);
      queue_instr("sw_wait15", 6'h2B, 6'h00, 5'd2, 1'b0, 1'b0, 1'b0, 0, TIMEOUT - 1);
      while (sb.size() != 0) begin
         e = sb.pop_front();
         step(e);
         n_total++;
         if (ctl_now !== e.ctl || retired !== e.ret)
            $display("FAIL %s: got ctl=%05h ret=%0d want ctl=%05h ret=%0d",
                     e.tag, ctl_now, retired, e.ctl, e.ret);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_illegal();
      queue_instr("op3f", 6'h3F, 6'h00, 5'd0, 1'b0, 1'b0, 1'b0, 0, 0);
      queue_instr("rtype_2a", 6'h00, 6'h2A, 5'd0, 1'b0, 1'b0, 1'b0, 0, 0);
      queue_instr("regimm_rt0", 6'h01, 6'h00, 5'd0, 1'b0, 1'b0, 1'b0, 0, 0);
      queue_instr("after_ill", 6'h08, 6'h00, 5'd0, 1'b0, 1'b0, 1'b0, 0, 0);
      while (sb.size() != 0) begin
         e = sb.pop_front();
         step(e);
         n_total++;
         if (ctl_now !== e.ctl || retired !== e.ret)
            $display("FAIL %s: got ctl=%05h ret=%0d want ctl=%05h ret=%0d",
                     e.tag, ctl_now, retired, e.ctl, e.ret);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_overflow();
      queue_instr("addi_ovf", 6'h08, 6'h00, 5'd0, 1'b0, 1'b0, 1'b1, 0, 0);
      queue_instr("sub_ovf", 6'h00, 6'h22, 5'd0, 1'b0, 1'b0, 1'b1, 0, 0);
      while (sb.size() != 0) begin
         e = sb.pop_front();
         step(e);
         n_total++;
         if (ctl_now !== e.ctl || retired !== e.ret)
            $display("FAIL %s: got ctl=%05h ret=%0d want ctl=%05h ret=%0d",
                     e.tag, ctl_now, retired, e.ctl, e.ret);
         else n_pass++;
         tick();
      end
      do_reset();
   endtask

   task automatic test_timeout();
      queue_instr("lw_timeout", 6'h23, 6'h00, 5'd2, 1'b0, 1'b0, 1'b0, 0, TIMEOUT);
      while (sb.size() != 0) begin
         e = sb.pop_front();
         step(e);
         n_total++;
         if (ctl_now !== e.ctl || retired !== e.ret)
            $display("FAIL %s: got ctl=%05h ret=%0d want ctl=%05h ret=%0d",
                     e.tag, ctl_now, retired, e.ctl, e.ret);
         else n_pass++;
         tick();
      end
      do_reset();
   endtask

   task automatic test_back_to_back();
      logic [5:0] op, fn;
      logic [4:0] rt;
      for (int i = 0; i < 22; i++) begin
         fn = 6'h00;
         rt = 5'd0;
         case ($urandom_range(0, 12))
            0:  fn = 6'h20;
            1:  fn = 6'h22;
            2:  fn = 6'h08;
            default: ;
         endcase
         case ($urandom_range(0, 9))
            0: op = 6'h00;
            1: op = 6'h08;
            2: op = 6'h0E;
            3: op = 6'h04;
            4: op = 6'h05;
            5: begin op = 6'h01; rt = 5'd1; end
            6: op = 6'h02;
            7: op = 6'h03;
            8: op = 6'h23;
            default: op = ($urandom_range(0, 3) == 0) ? 6'h3F : 6'h2B;
         endcase
         queue_instr("b2b", op, fn, rt, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 2),
                     $urandom_range(0, 2));
      end
      while (sb.size() != 0) begin
         e = sb.pop_front();
         step(e);
         n_total++;
         if (ctl_now !== e.ctl || retired !== e.ret)
            $display("FAIL %s: got ctl=%05h ret=%0d want ctl=%05h ret=%0d",
                     e.tag, ctl_now, retired, e.ctl, e.ret);
         else n_pass++;
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_branch();
      test_jump();
      test_mem();
      test_illegal();
      test_back_to_back();
      test_overflow();
      test_timeout();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
